// File: rtl/ram_host_port_pkg.sv
// Shared definitions for the RAM host port: DIN_SIZE encodings and the
// host-port FSM state type.
package ram_host_port_pkg;

    localparam logic [1:0] DIN_SIZE_8  = 2'd0;
    localparam logic [1:0] DIN_SIZE_16 = 2'd1;
    localparam logic [1:0] DIN_SIZE_32 = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_SLOT = 2'd1,
        ST_ACCESS    = 2'd2,
        ST_REFRESH   = 2'd3
    } state_t;

endpackage

// File: rtl/ram_host_port_if.sv
// Shared RAM bus (RAM_IF). The master modport is the host side
// (address, data, size, active-low strobes out; read data, ack, slot timing in).
// The slave modport is the RAM/merger side.
interface ram_if
    import ram_host_port_pkg::*;
#(
    parameter int ADDR_BIT_WIDTH = 24
);
    logic [ADDR_BIT_WIDTH-1:0] addr;
    logic [31:0]               din;
    logic [1:0]                din_size;
    logic                      oe_n;
    logic                      we_n;
    logic                      rfsh_n;
    logic [31:0]               dout;
    logic                      ack_n;
    logic                      timing;

    modport master (
        output addr, din, din_size, oe_n, we_n, rfsh_n,
        input  dout, ack_n, timing
    );

    modport slave (
        input  addr, din, din_size, oe_n, we_n, rfsh_n,
        output dout, ack_n, timing
    );
endinterface

// File: rtl/ram_host_port_refresh.sv
// Refresh interval timer for the RAM host port.
// Ports: i_clk, i_reset_n (async active-low), i_clr_pending (refresh served),
//        o_pending (refresh owed), o_late (sticky: interval expired while owed).
// RFSH_INTERVAL=0 removes the timer entirely; outputs are held low.
module ram_refresh_timer
    import ram_host_port_pkg::*;
#(
    parameter int RFSH_INTERVAL = 780
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_clr_pending,
    output logic o_pending,
    output logic o_late
);
    generate
        if (RFSH_INTERVAL == 0) begin : g_off
            logic w_unused;
            assign w_unused  = &{1'b0, i_clk, i_reset_n, i_clr_pending};
            assign o_pending = 1'b0;
            assign o_late    = 1'b0;
        end else begin : g_on
            localparam int CNT_W = (RFSH_INTERVAL > 1) ? $clog2(RFSH_INTERVAL) : 1;
            localparam logic [CNT_W-1:0] LAST = CNT_W'(RFSH_INTERVAL - 1);

            logic [CNT_W-1:0] r_cnt;
            logic             r_pending;
            logic             r_late;
            logic             w_wrap;

            assign w_wrap = (r_cnt == LAST);

            always_ff @(posedge i_clk or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    r_cnt     <= '0;
                    r_pending <= 1'b0;
                    r_late    <= 1'b0;
                end else begin
                    r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
                    // A new interval beats a clear on the same edge; pending never stacks.
                    if (w_wrap)
                        r_pending <= 1'b1;
                    else if (i_clr_pending)
                        r_pending <= 1'b0;
                    // Being served on the wrap edge is not late.
                    if (w_wrap && r_pending && !i_clr_pending)
                        r_late <= 1'b1;
                end
            end

            assign o_pending = r_pending;
            assign o_late    = r_late;
        end
    endgenerate
endmodule

// File: rtl/ram_host_port.sv
// Per-client RAM host port: turns a REQ/READY/DONE client handshake into one
// RAM bus access per request and inserts periodic refresh cycles.
// Ports: i_clk, i_reset_n (async active-low); client i_req/i_wr/i_addr/i_din/
//        i_din_size in, o_ready/o_done/o_dout/o_rfsh_late out; ram (RAM bus, host side).
// When not accessing, every bus field is driven zero and every strobe high so
// several ports can be OR/AND-merged onto one RAM.
module ram_host_port
    import ram_host_port_pkg::*;
#(
    parameter int ADDR_BIT_WIDTH = 24,
    parameter int RFSH_INTERVAL  = 780
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      i_req,
    input  logic                      i_wr,
    input  logic [ADDR_BIT_WIDTH-1:0] i_addr,
    input  logic [31:0]               i_din,
    input  logic [1:0]                i_din_size,
    output logic                      o_ready,
    output logic                      o_done,
    output logic [31:0]               o_dout,
    output logic                      o_rfsh_late,
    ram_if.master                     ram
);
    state_t                    r_state;
    logic                      r_op_valid;
    logic                      r_wr;
    logic [ADDR_BIT_WIDTH-1:0] r_addr;
    logic [31:0]               r_din;
    logic [1:0]                r_size;
    logic                      r_ready;
    logic                      r_done;
    logic [31:0]               r_dout;
    logic [ADDR_BIT_WIDTH-1:0] r_bus_addr;
    logic [31:0]               r_bus_din;
    logic [1:0]                r_bus_size;
    logic                      r_oe_n;
    logic                      r_we_n;
    logic                      r_rfsh_n;
    logic                      w_pending;
    logic                      w_clr_pending;

    assign w_clr_pending = (r_state == ST_REFRESH) && !ram.ack_n;

    ram_refresh_timer #(
        .RFSH_INTERVAL(RFSH_INTERVAL)
    ) u_timer (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_clr_pending(w_clr_pending),
        .o_pending    (w_pending),
        .o_late       (o_rfsh_late)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= ST_IDLE;
            r_op_valid <= 1'b0;
            r_wr       <= 1'b0;
            r_addr     <= '0;
            r_din      <= '0;
            r_size     <= DIN_SIZE_8;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_dout     <= '0;
            r_bus_addr <= '0;
            r_bus_din  <= '0;
            r_bus_size <= DIN_SIZE_8;
            r_oe_n     <= 1'b1;
            r_we_n     <= 1'b1;
            r_rfsh_n   <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_req) begin
                        r_op_valid <= 1'b1;
                        r_wr       <= i_wr;
                        r_addr     <= i_addr;
                        r_din      <= i_din;
                        r_size     <= i_din_size;
                        r_ready    <= 1'b0;
                        r_state    <= ST_WAIT_SLOT;
                    end else if (w_pending) begin
                        r_ready <= 1'b0;
                        r_state <= ST_WAIT_SLOT;
                    end
                end
                ST_WAIT_SLOT: begin
                    if (ram.timing) begin
                        // Refresh takes the slot; a latched client op waits for the next one.
                        if (w_pending) begin
                            r_rfsh_n <= 1'b0;
                            r_state  <= ST_REFRESH;
                        end else if (r_op_valid) begin
                            r_bus_addr <= r_addr;
                            if (r_wr) begin
                                r_we_n     <= 1'b0;
                                r_bus_din  <= r_din;
                                r_bus_size <= r_size;
                            end else begin
                                r_oe_n <= 1'b0;
                            end
                            r_state <= ST_ACCESS;
                        end else begin
                            r_ready <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (!ram.ack_n) begin
                        r_bus_addr <= '0;
                        r_bus_din  <= '0;
                        r_bus_size <= DIN_SIZE_8;
                        r_oe_n     <= 1'b1;
                        r_we_n     <= 1'b1;
                        if (!r_wr)
                            r_dout <= ram.dout;
                        r_done     <= 1'b1;
                        r_ready    <= 1'b1;
                        r_op_valid <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                ST_REFRESH: begin
                    if (!ram.ack_n) begin
                        r_rfsh_n <= 1'b1;
                        if (r_op_valid) begin
                            r_state <= ST_WAIT_SLOT;
                        end else begin
                            r_ready <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_ready      = r_ready;
    assign o_done       = r_done;
    assign o_dout       = r_dout;
    assign ram.addr     = r_bus_addr;
    assign ram.din      = r_bus_din;
    assign ram.din_size = r_bus_size;
    assign ram.oe_n     = r_oe_n;
    assign ram.we_n     = r_we_n;
    assign ram.rfsh_n   = r_rfsh_n;
endmodule

// File: tb/tb_ram_host_port.sv
// Bench for ram_host_port: instance 0 refreshes every 16 cycles, instances 1
// and 2 have refresh disabled and are OR/AND-merged like a RAM expansion merger.
module tb_ram_host_port;
    import ram_host_port_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req    [3];
    logic        wr     [3];
    logic [23:0] addr   [3];
    logic [31:0] din    [3];
    logic [1:0]  dsz    [3];
    logic        ready  [3];
    logic        done   [3];
    logic [31:0] dout   [3];
    logic        late   [3];
    logic        timing [3];
    logic        ack_n  [3];
    logic [31:0] rdata  [3];

    int n_checks = 0;
    int n_pass   = 0;
    int mon_la;
    int mon_lbc;

    ram_if #(.ADDR_BIT_WIDTH(24)) if_a ();
    ram_if #(.ADDR_BIT_WIDTH(24)) if_b ();
    ram_if #(.ADDR_BIT_WIDTH(24)) if_c ();

    assign if_a.timing = timing[0];
    assign if_a.ack_n  = ack_n[0];
    assign if_a.dout   = rdata[0];
    assign if_b.timing = timing[1];
    assign if_b.ack_n  = ack_n[1];
    assign if_b.dout   = rdata[1];
    assign if_c.timing = timing[2];
    assign if_c.ack_n  = ack_n[2];
    assign if_c.dout   = rdata[2];

    logic [23:0] m_addr;
    logic [31:0] m_din;
    logic [1:0]  m_size;
    logic        m_oe_n;
    logic        m_we_n;
    assign m_addr = if_b.addr | if_c.addr;
    assign m_din  = if_b.din | if_c.din;
    assign m_size = if_b.din_size | if_c.din_size;
    assign m_oe_n = if_b.oe_n & if_c.oe_n;
    assign m_we_n = if_b.we_n & if_c.we_n;

    ram_host_port #(.ADDR_BIT_WIDTH(24), .RFSH_INTERVAL(16)) u_a (
        .i_clk(clk), .i_reset_n(rst_n), .i_req(req[0]), .i_wr(wr[0]), .i_addr(addr[0]),
        .i_din(din[0]), .i_din_size(dsz[0]), .o_ready(ready[0]), .o_done(done[0]),
        .o_dout(dout[0]), .o_rfsh_late(late[0]), .ram(if_a)
    );
    ram_host_port #(.ADDR_BIT_WIDTH(24), .RFSH_INTERVAL(0)) u_b (
        .i_clk(clk), .i_reset_n(rst_n), .i_req(req[1]), .i_wr(wr[1]), .i_addr(addr[1]),
        .i_din(din[1]), .i_din_size(dsz[1]), .o_ready(ready[1]), .o_done(done[1]),
        .o_dout(dout[1]), .o_rfsh_late(late[1]), .ram(if_b)
    );
    ram_host_port #(.ADDR_BIT_WIDTH(24), .RFSH_INTERVAL(0)) u_c (
        .i_clk(clk), .i_reset_n(rst_n), .i_req(req[2]), .i_wr(wr[2]), .i_addr(addr[2]),
        .i_din(din[2]), .i_din_size(dsz[2]), .o_ready(ready[2]), .o_done(done[2]),
        .o_dout(dout[2]), .o_rfsh_late(late[2]), .ram(if_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe exclusivity, every cycle out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            mon_la  = int'(!if_a.oe_n) + int'(!if_a.we_n) + int'(!if_a.rfsh_n);
            mon_lbc = int'(!if_b.oe_n) + int'(!if_b.we_n) + int'(!if_b.rfsh_n)
                    + int'(!if_c.oe_n) + int'(!if_c.we_n) + int'(!if_c.rfsh_n);
            n_checks++;
            if (mon_la > 1 || mon_lbc > 1)
                $display("FAIL strobe_overlap: got a_low=%0d bc_low=%0d want <=1", mon_la, mon_lbc);
            else
                n_pass++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic issue(input int k, input logic w, input logic [23:0] a,
                         input logic [31:0] d, input logic [1:0] s);
        req[k] = 1'b1; wr[k] = w; addr[k] = a; din[k] = d; dsz[k] = s;
        cyc();
        req[k] = 1'b0;
        timing[k] = 1'b1;
        cyc();
        timing[k] = 1'b0;
    endtask

    task automatic ack(input int k, input logic [31:0] rd);
        ack_n[k] = 1'b0;
        rdata[k] = rd;
        cyc();
        ack_n[k] = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (ready[0] !== 1'b1) $display("FAIL rst_ready: got %b want 1", ready[0]); else n_pass++;
        n_checks++; if (done[0] !== 1'b0) $display("FAIL rst_done: got %b want 0", done[0]); else n_pass++;
        n_checks++; if (dout[0] !== 32'h0) $display("FAIL rst_dout: got %h want 0", dout[0]); else n_pass++;
        n_checks++; if (late[0] !== 1'b0) $display("FAIL rst_late: got %b want 0", late[0]); else n_pass++;
        n_checks++; if ({if_a.addr, if_a.din, if_a.din_size} !== 58'h0)
            $display("FAIL rst_bus: got addr=%h din=%h size=%h want 0", if_a.addr, if_a.din, if_a.din_size); else n_pass++;
        n_checks++; if ({if_a.oe_n, if_a.we_n, if_a.rfsh_n} !== 3'b111)
            $display("FAIL rst_strobes: got %b want 111", {if_a.oe_n, if_a.we_n, if_a.rfsh_n}); else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_read();
        issue(1, 1'b0, 24'h001234, 32'h0, DIN_SIZE_8);
        n_checks++; if ({if_b.oe_n, if_b.we_n} !== 2'b01) $display("FAIL rd_strobe: got oe/we=%b want 01", {if_b.oe_n, if_b.we_n}); else n_pass++;
        n_checks++; if (if_b.addr !== 24'h001234) $display("FAIL rd_addr: got %h want 001234", if_b.addr); else n_pass++;
        n_checks++; if (if_b.din !== 32'h0) $display("FAIL rd_din: got %h want 0", if_b.din); else n_pass++;
        n_checks++; if (ready[1] !== 1'b0) $display("FAIL rd_ready_busy: got %b want 0", ready[1]); else n_pass++;
        cyc();
        n_checks++; if (if_b.oe_n !== 1'b0 || done[1] !== 1'b0)
            $display("FAIL rd_hold: got oe=%b done=%b want 0 0", if_b.oe_n, done[1]); else n_pass++;
        ack(1, 32'hDEADBEEF);
        n_checks++; if (done[1] !== 1'b1) $display("FAIL rd_done: got %b want 1", done[1]); else n_pass++;
        n_checks++; if (dout[1] !== 32'hDEADBEEF) $display("FAIL rd_dout: got %h want deadbeef", dout[1]); else n_pass++;
        n_checks++; if (if_b.oe_n !== 1'b1 || if_b.addr !== 24'h0)
            $display("FAIL rd_release: got oe=%b addr=%h want 1 0", if_b.oe_n, if_b.addr); else n_pass++;
        n_checks++; if (ready[1] !== 1'b1) $display("FAIL rd_ready: got %b want 1", ready[1]); else n_pass++;
        cyc();
        n_checks++; if (done[1] !== 1'b0 || dout[1] !== 32'hDEADBEEF)
            $display("FAIL rd_after: got done=%b dout=%h want 0 deadbeef", done[1], dout[1]); else n_pass++;
    endtask

    task automatic test_write();
        issue(1, 1'b1, 24'h00FF00, 32'h000000A5, DIN_SIZE_8);
        n_checks++; if ({if_b.oe_n, if_b.we_n} !== 2'b10) $display("FAIL wr_strobe: got oe/we=%b want 10", {if_b.oe_n, if_b.we_n}); else n_pass++;
        n_checks++; if (if_b.addr !== 24'h00FF00 || if_b.din !== 32'hA5 || if_b.din_size !== DIN_SIZE_8)
            $display("FAIL wr_bus: got addr=%h din=%h size=%h want 00ff00 a5 0", if_b.addr, if_b.din, if_b.din_size); else n_pass++;
        ack(1, 32'h11111111);
        n_checks++; if (done[1] !== 1'b1) $display("FAIL wr_done: got %b want 1", done[1]); else n_pass++;
        n_checks++; if (dout[1] !== 32'hDEADBEEF) $display("FAIL wr_dout_kept: got %h want deadbeef", dout[1]); else n_pass++;
        n_checks++; if (if_b.we_n !== 1'b1 || if_b.din !== 32'h0)
            $display("FAIL wr_release: got we=%b din=%h want 1 0", if_b.we_n, if_b.din); else n_pass++;
        cyc();
        n_checks++; if (done[1] !== 1'b0) $display("FAIL wr_done_pulse: got %b want 0", done[1]); else n_pass++;
    endtask

    task automatic test_idle_zero();
        issue(2, 1'b1, 24'h000ABC, 32'h12345678, DIN_SIZE_32);
        n_checks++; if (m_addr !== 24'h000ABC || m_din !== 32'h12345678 || m_size !== DIN_SIZE_32)
            $display("FAIL mrg_c_bus: got addr=%h din=%h size=%h want 000abc 12345678 2", m_addr, m_din, m_size); else n_pass++;
        n_checks++; if ({m_oe_n, m_we_n} !== 2'b10) $display("FAIL mrg_c_strobe: got %b want 10", {m_oe_n, m_we_n}); else n_pass++;
        ack(2, 32'h0);
        cyc();
        issue(1, 1'b0, 24'h0000F0, 32'hFFFFFFFF, DIN_SIZE_32);
        n_checks++; if (m_addr !== 24'h0000F0 || m_din !== 32'h0 || m_size !== DIN_SIZE_8)
            $display("FAIL mrg_b_bus: got addr=%h din=%h size=%h want 0000f0 0 0", m_addr, m_din, m_size); else n_pass++;
        n_checks++; if ({m_oe_n, m_we_n} !== 2'b01) $display("FAIL mrg_b_strobe: got %b want 01", {m_oe_n, m_we_n}); else n_pass++;
        ack(1, 32'h0BADF00D);
        n_checks++; if (dout[1] !== 32'h0BADF00D || done[2] !== 1'b0)
            $display("FAIL mrg_b_dout: got %h done_c=%b want 0badf00d 0", dout[1], done[2]); else n_pass++;
        n_checks++; if (m_addr !== 24'h0 || m_din !== 32'h0) $display("FAIL mrg_idle: got addr=%h din=%h want 0 0", m_addr, m_din); else n_pass++;
    endtask

    task automatic test_refresh_conflict();
        apply_reset();
        for (int i = 0; i < 15; i++) cyc();
        req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 24'h005555; din[0] = 32'h0; dsz[0] = DIN_SIZE_8;
        cyc();
        req[0] = 1'b0;
        timing[0] = 1'b1;
        cyc();
        timing[0] = 1'b0;
        n_checks++; if ({if_a.rfsh_n, if_a.oe_n, if_a.we_n} !== 3'b011)
            $display("FAIL cf_rfsh: got rfsh/oe/we=%b want 011", {if_a.rfsh_n, if_a.oe_n, if_a.we_n}); else n_pass++;
        n_checks++; if (if_a.addr !== 24'h0 || ready[0] !== 1'b0)
            $display("FAIL cf_rfsh_bus: got addr=%h ready=%b want 0 0", if_a.addr, ready[0]); else n_pass++;
        ack(0, 32'h0);
        n_checks++; if (if_a.rfsh_n !== 1'b1 || done[0] !== 1'b0 || ready[0] !== 1'b0 || if_a.oe_n !== 1'b1)
            $display("FAIL cf_after_rfsh: got rfsh=%b done=%b ready=%b oe=%b want 1 0 0 1",
                     if_a.rfsh_n, done[0], ready[0], if_a.oe_n); else n_pass++;
        timing[0] = 1'b1;
        cyc();
        timing[0] = 1'b0;
        n_checks++; if (if_a.oe_n !== 1'b0 || if_a.addr !== 24'h005555 || if_a.rfsh_n !== 1'b1)
            $display("FAIL cf_access: got oe=%b addr=%h rfsh=%b want 0 005555 1", if_a.oe_n, if_a.addr, if_a.rfsh_n); else n_pass++;
        ack(0, 32'hCAFEF00D);
        n_checks++; if (done[0] !== 1'b1 || dout[0] !== 32'hCAFEF00D)
            $display("FAIL cf_done: got done=%b dout=%h want 1 cafef00d", done[0], dout[0]); else n_pass++;
        cyc();
        n_checks++; if (done[0] !== 1'b0 || late[0] !== 1'b0)
            $display("FAIL cf_single_done: got done=%b late=%b want 0 0", done[0], late[0]); else n_pass++;
    endtask

    task automatic test_late_refresh();
        int rf_low;
        apply_reset();
        for (int i = 0; i < 31; i++) cyc();
        n_checks++; if (late[0] !== 1'b0 || ready[0] !== 1'b0)
            $display("FAIL late_before: got late=%b ready=%b want 0 0", late[0], ready[0]); else n_pass++;
        cyc();
        n_checks++; if (late[0] !== 1'b1) $display("FAIL late_set: got %b want 1", late[0]); else n_pass++;
        for (int i = 0; i < 8; i++) cyc();
        timing[0] = 1'b1;
        cyc();
        timing[0] = 1'b0;
        n_checks++; if (if_a.rfsh_n !== 1'b0) $display("FAIL late_rfsh: got %b want 0", if_a.rfsh_n); else n_pass++;
        ack(0, 32'h0);
        n_checks++; if (if_a.rfsh_n !== 1'b1 || ready[0] !== 1'b1)
            $display("FAIL late_rfsh_end: got rfsh=%b ready=%b want 1 1", if_a.rfsh_n, ready[0]); else n_pass++;
        timing[0] = 1'b1;
        rf_low = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (if_a.rfsh_n === 1'b0) rf_low++;
        end
        timing[0] = 1'b0;
        n_checks++; if (rf_low !== 0) $display("FAIL late_single_rfsh: got %0d extra refresh cycles want 0", rf_low); else n_pass++;
        n_checks++; if (late[0] !== 1'b1) $display("FAIL late_sticky: got %b want 1", late[0]); else n_pass++;
    endtask

    task automatic test_reset_mid_access();
        issue(1, 1'b1, 24'h000777, 32'h00000001, DIN_SIZE_8);
        n_checks++; if (if_b.we_n !== 1'b0) $display("FAIL mid_we_low: got %b want 0", if_b.we_n); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (if_b.we_n !== 1'b1 || if_b.addr !== 24'h0 || if_b.din !== 32'h0)
            $display("FAIL mid_async: got we=%b addr=%h din=%h want 1 0 0", if_b.we_n, if_b.addr, if_b.din); else n_pass++;
        cyc();
        rst_n = 1'b1;
        ack_n[1] = 1'b0;
        cyc();
        ack_n[1] = 1'b1;
        n_checks++; if (ready[1] !== 1'b1 || done[1] !== 1'b0 || if_b.we_n !== 1'b1)
            $display("FAIL mid_after: got ready=%b done=%b we=%b want 1 0 1", ready[1], done[1], if_b.we_n); else n_pass++;
        cyc();
        n_checks++; if (done[1] !== 1'b0) $display("FAIL mid_no_done: got %b want 0", done[1]); else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0; din[k] = '0; dsz[k] = DIN_SIZE_8;
            timing[k] = 1'b0; ack_n[k] = 1'b1; rdata[k] = '0;
        end
        test_reset();
        cyc();
        test_read();
        test_write();
        test_idle_zero();
        test_refresh_conflict();
        test_late_refresh();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
